// File: rtl/ripple_cnt_monitor.sv
// ripple_cnt_monitor
//   Consumes the Q3..Q0 outputs of a 4-bit JK ripple counter. These outputs are
//   asynchronous to clk. The bits are brought into the clk domain through a
//   two-flop synchroniser. A stability filter then rejects the intermediate
//   codes that appear while the counter ripples. The block publishes the
//   filtered count, one-cycle wrap and threshold-match events, and a saturating
//   count of wrap-arounds.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   cnt_in       raw ripple counter bits {Q3,Q2,Q1,Q0}
//   threshold    match value, sampled on every acceptance
//   clr_wrap     synchronous clear of wrap_total / wrap_sat
//   cnt_sync     last accepted count
//   cnt_valid    a count has been accepted since reset
//   wrap_pulse   accepted count is below the previous accepted count
//   match_pulse  accepted count changed to threshold
//   wrap_total   saturating number of wrap events
//   wrap_sat     sticky: a wrap arrived while wrap_total was at its maximum
module ripple_cnt_monitor #(
    parameter int STABLE = 2,
    parameter int WRAP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        cnt_in,
    input  logic [3:0]        threshold,
    input  logic              clr_wrap,
    output logic [3:0]        cnt_sync,
    output logic              cnt_valid,
    output logic              wrap_pulse,
    output logic              match_pulse,
    output logic [WRAP_W-1:0] wrap_total,
    output logic              wrap_sat
);

    localparam logic [1:0] S_INIT   = 2'd0;
    localparam logic [1:0] S_TRACK  = 2'd1;
    localparam logic [1:0] S_SETTLE = 2'd2;

    localparam logic [3:0]        STABLE_L = 4'(STABLE);
    localparam logic [WRAP_W-1:0] WRAP_MAX = '1;
    localparam logic [WRAP_W-1:0] WRAP_ONE = {{(WRAP_W-1){1'b0}}, 1'b1};

    logic [3:0]        s1_q, s1_d, s2_q, s2_d;
    logic [1:0]        fill_q, fill_d;
    logic [1:0]        state_q, state_d;
    logic [3:0]        cand_q, cand_d;
    logic [3:0]        stab_q, stab_d;
    logic [3:0]        cnt_sync_q, cnt_sync_d;
    logic              cnt_valid_q, cnt_valid_d;
    logic              wrap_pulse_q, wrap_pulse_d;
    logic              match_pulse_q, match_pulse_d;
    logic [WRAP_W-1:0] wrap_total_q, wrap_total_d;
    logic              wrap_sat_q, wrap_sat_d;

    logic [3:0]        stab_inc;
    logic [WRAP_W-1:0] wrap_base;
    logic              sat_base;

    always_comb begin
        s1_d          = cnt_in;
        s2_d          = s1_q;
        // s2 only holds a real cnt_in sample two edges after reset. Until then
        // it holds the reset zeros, which must not be qualified as a count.
        fill_d        = (fill_q == 2'd2) ? fill_q : fill_q + 2'd1;
        state_d       = state_q;
        cand_d        = cand_q;
        stab_d        = stab_q;
        cnt_sync_d    = cnt_sync_q;
        cnt_valid_d   = cnt_valid_q;
        wrap_pulse_d  = 1'b0;
        match_pulse_d = 1'b0;
        stab_inc      = stab_q + 4'd1;

        case (state_q)
            S_INIT: begin
                if (fill_q == 2'd2) begin
                    // stab == 0 means no candidate has been loaded yet. This
                    // keeps a reset-valued cand from matching a sample early.
                    if ((stab_q != 4'd0) && (s2_q == cand_q)) begin
                        if (stab_inc == STABLE_L) begin
                            cnt_sync_d  = cand_q;
                            cnt_valid_d = 1'b1;
                            state_d     = S_TRACK;
                        end else begin
                            stab_d = stab_inc;
                        end
                    end else begin
                        cand_d = s2_q;
                        stab_d = 4'd1;
                    end
                end
            end
            S_TRACK: begin
                if (s2_q != cnt_sync_q) begin
                    cand_d  = s2_q;
                    stab_d  = 4'd1;
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (s2_q == cnt_sync_q) begin
                    // Fell back to the published value: the candidate was a glitch.
                    state_d = S_TRACK;
                end else if (s2_q != cand_q) begin
                    cand_d = s2_q;
                    stab_d = 4'd1;
                end else if (stab_inc == STABLE_L) begin
                    cnt_sync_d    = cand_q;
                    wrap_pulse_d  = (cand_q < cnt_sync_q);
                    match_pulse_d = (cand_q == threshold);
                    state_d       = S_TRACK;
                end else begin
                    stab_d = stab_inc;
                end
            end
            default: state_d = S_INIT;
        endcase

        // Apply the clear first, then count the wrap event on top of it.
        wrap_base    = clr_wrap ? '0 : wrap_total_q;
        sat_base     = clr_wrap ? 1'b0 : wrap_sat_q;
        wrap_total_d = wrap_base;
        wrap_sat_d   = sat_base;
        if (wrap_pulse_q) begin
            if (wrap_base == WRAP_MAX) begin
                wrap_sat_d = 1'b1;
            end else begin
                wrap_total_d = wrap_base + WRAP_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q          <= '0;
            s2_q          <= '0;
            fill_q        <= '0;
            state_q       <= S_INIT;
            cand_q        <= '0;
            stab_q        <= '0;
            cnt_sync_q    <= '0;
            cnt_valid_q   <= 1'b0;
            wrap_pulse_q  <= 1'b0;
            match_pulse_q <= 1'b0;
            wrap_total_q  <= '0;
            wrap_sat_q    <= 1'b0;
        end else begin
            s1_q          <= s1_d;
            s2_q          <= s2_d;
            fill_q        <= fill_d;
            state_q       <= state_d;
            cand_q        <= cand_d;
            stab_q        <= stab_d;
            cnt_sync_q    <= cnt_sync_d;
            cnt_valid_q   <= cnt_valid_d;
            wrap_pulse_q  <= wrap_pulse_d;
            match_pulse_q <= match_pulse_d;
            wrap_total_q  <= wrap_total_d;
            wrap_sat_q    <= wrap_sat_d;
        end
    end

    assign cnt_sync    = cnt_sync_q;
    assign cnt_valid   = cnt_valid_q;
    assign wrap_pulse  = wrap_pulse_q;
    assign match_pulse = match_pulse_q;
    assign wrap_total  = wrap_total_q;
    assign wrap_sat    = wrap_sat_q;

endmodule

// File: tb/tb_ripple_cnt_monitor.sv
// Testbench for ripple_cnt_monitor (STABLE=2, WRAP_W=2).
// The reference model works on the sequence of synchronised samples. A new
// value is accepted once it has been seen on STABLE consecutive edges and it
// differs from the published count.
module tb_ripple_cnt_monitor;
    localparam int STABLE = 2;
    localparam int WRAP_W = 2;
    localparam int OBS_W  = 4 + 1 + 1 + 1 + WRAP_W + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [3:0]        cnt_in;
    logic [3:0]        threshold;
    logic              clr_wrap;
    logic [3:0]        cnt_sync;
    logic              cnt_valid;
    logic              wrap_pulse;
    logic              match_pulse;
    logic [WRAP_W-1:0] wrap_total;
    logic              wrap_sat;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ripple_cnt_monitor #(.STABLE(STABLE), .WRAP_W(WRAP_W)) dut (
        .clk(clk), .rst(rst), .cnt_in(cnt_in), .threshold(threshold),
        .clr_wrap(clr_wrap), .cnt_sync(cnt_sync), .cnt_valid(cnt_valid),
        .wrap_pulse(wrap_pulse), .match_pulse(match_pulse),
        .wrap_total(wrap_total), .wrap_sat(wrap_sat)
    );

    // ---------------- reference model ----------------
    logic [3:0] m_hist[$];   // cnt_in values captured on recent edges
    int         m_run;       // consecutive edges the current sample has been seen
    logic [3:0] m_last, m_acc, smp;
    logic       m_valid, m_wrap, m_match, m_sat, b_sat;
    int         m_total, b_total;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_hist.delete();
            m_run = 0; m_last = 0; m_acc = 0; m_valid = 0;
            m_wrap = 0; m_match = 0; m_total = 0; m_sat = 0;
        end else begin
            b_total = clr_wrap ? 0 : m_total;
            b_sat   = clr_wrap ? 1'b0 : m_sat;
            if (m_wrap) begin
                if (b_total == (1 << WRAP_W) - 1) b_sat = 1'b1;
                else b_total = b_total + 1;
            end
            m_total = b_total;
            m_sat   = b_sat;
            m_wrap  = 0;
            m_match = 0;
            // The filter sees the value captured two edges ago.
            if (m_hist.size() == 2) begin
                smp    = m_hist[0];
                m_run  = (m_run > 0 && smp == m_last) ? m_run + 1 : 1;
                m_last = smp;
                if (m_run == STABLE && (!m_valid || smp != m_acc)) begin
                    if (m_valid) begin
                        m_wrap  = (smp < m_acc);
                        m_match = (smp == threshold);
                    end
                    m_acc   = smp;
                    m_valid = 1;
                end
            end
            m_hist.push_back(cnt_in);
            if (m_hist.size() > 2) void'(m_hist.pop_front());
        end
    end

    wire [OBS_W-1:0] obs     = {cnt_sync, cnt_valid, wrap_pulse, match_pulse, wrap_total, wrap_sat};
    wire [OBS_W-1:0] exp_vec = {m_acc, m_valid, m_wrap, m_match, WRAP_W'(m_total), m_sat};

    // Drive cnt_in, then advance one edge and settle just after it.
    task automatic tick(input logic [3:0] v);
        cnt_in = v;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1; cnt_in = 4'h5; threshold = 4'h5; clr_wrap = 0;
        #3;
        n_checks++;
        if (obs !== '0) begin
            n_fail++; $display("FAIL reset_outputs obs=%h required=0", obs);
        end
        for (int i = 0; i < 3; i++) begin
            tick(4'h5);
            n_checks++;
            if (obs !== exp_vec) begin
                n_fail++; $display("FAIL reset_hold obs=%h required=%h", obs, exp_vec);
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_first_accept;
        rst = 0;
        for (int k = 1; k <= 6; k++) begin
            tick(4'h5);
            n_checks++;
            if (obs !== exp_vec) begin
                n_fail++; $display("FAIL first_model k=%0d obs=%h required=%h", k, obs, exp_vec);
            end
            n_checks++;
            if (cnt_valid !== (k >= 4) || (k >= 4 && cnt_sync !== 4'h5) || wrap_pulse !== 0 || match_pulse !== 0) begin
                n_fail++;
                $display("FAIL first_latency k=%0d valid=%b sync=%h wp=%b mp=%b required valid=%b sync=5 pulses=0",
                         k, cnt_valid, cnt_sync, wrap_pulse, match_pulse, k >= 4);
            end
        end
        $display("test_first_accept done cnt_sync=%h", cnt_sync);
    endtask

    task automatic test_ripple;
        logic [3:0] seq[10];
        seq = '{4'h7, 4'h7, 4'h7, 4'h7, 4'h6, 4'h4, 4'h0, 4'h8, 4'h8, 4'h8};
        for (int i = 0; i < 14; i++) begin
            tick(seq[i < 10 ? i : 9]);
            n_checks++;
            if (obs !== exp_vec || wrap_pulse !== 0 ||
                (i >= 3 && cnt_sync !== 4'h7 && cnt_sync !== 4'h8)) begin
                n_fail++; $display("FAIL ripple i=%0d obs=%h required=%h sync in {7,8}", i, obs, exp_vec);
            end
        end
        n_checks++;
        if (cnt_sync !== 4'h8) begin
            n_fail++; $display("FAIL ripple_final cnt_sync=%h required=8", cnt_sync);
        end
        $display("test_ripple done cnt_sync=%h", cnt_sync);
    endtask

    task automatic test_wrap;
        int wraps, both;
        for (int pass = 0; pass < 2; pass++) begin
            threshold = (pass == 0) ? 4'h5 : 4'h0;
            wraps = 0; both = 0;
            for (int i = 0; i < 6; i++) tick(4'hF);
            for (int i = 0; i < 6; i++) begin
                tick(4'h0);
                if (wrap_pulse) wraps++;
                if (wrap_pulse && match_pulse) both++;
                n_checks++;
                if (obs !== exp_vec) begin
                    n_fail++; $display("FAIL wrap_model pass=%0d obs=%h required=%h", pass, obs, exp_vec);
                end
            end
            n_checks++;
            if (wraps != 1 || cnt_sync !== 4'h0 || wrap_total !== WRAP_W'(pass + 1) || both != pass) begin
                n_fail++;
                $display("FAIL wrap_event pass=%0d wraps=%0d sync=%h total=%0d both=%0d required 1,0,%0d,%0d",
                         pass, wraps, cnt_sync, wrap_total, both, pass + 1, pass);
            end
            $display("test_wrap pass %0d wraps=%0d total=%0d", pass, wraps, wrap_total);
        end
    endtask

    task automatic test_glitch;
        int lat;
        threshold = 4'h9;
        for (int i = 0; i < 6; i++) tick(4'h3);
        tick(4'h9);
        for (int i = 0; i < 6; i++) begin
            tick(4'h3);
            n_checks++;
            if (obs !== exp_vec || cnt_sync !== 4'h3 || wrap_pulse !== 0 || match_pulse !== 0) begin
                n_fail++; $display("FAIL glitch i=%0d obs=%h required=%h sync=3", i, obs, exp_vec);
            end
        end
        lat = 0;
        for (int k = 1; k <= 10 && lat == 0; k++) begin
            tick(4'h4);
            if (cnt_sync === 4'h4) lat = k;
        end
        n_checks++;
        if (lat != STABLE + 2) begin
            n_fail++; $display("FAIL glitch_recover latency=%0d required=%0d", lat, STABLE + 2);
        end
        $display("test_glitch done latency=%0d", lat);
    endtask

    task automatic test_saturation;
        int found;
        clr_wrap = 1; tick(4'h4); clr_wrap = 0;
        n_checks++;
        if (wrap_total !== 0 || wrap_sat !== 0) begin
            n_fail++; $display("FAIL sat_clear total=%0d sat=%b required 0,0", wrap_total, wrap_sat);
        end
        for (int w = 0; w < 4; w++) begin
            for (int i = 0; i < 4; i++) tick(4'hF);
            for (int i = 0; i < 4; i++) tick(4'h0);
        end
        tick(4'h0); tick(4'h0);
        n_checks++;
        if (wrap_total !== 2'd3 || wrap_sat !== 1'b1 || obs !== exp_vec) begin
            n_fail++; $display("FAIL sat_four total=%0d sat=%b required 3,1", wrap_total, wrap_sat);
        end
        for (int i = 0; i < 4; i++) tick(4'hF);
        found = 0;
        for (int i = 0; i < 8 && found == 0; i++) begin
            tick(4'h0);
            if (wrap_pulse === 1'b1) found = 1;
        end
        n_checks++;
        if (found == 0) begin
            n_fail++; $display("FAIL sat_fifth_wrap seen=0 required=1");
        end
        clr_wrap = 1; tick(4'h0); clr_wrap = 0;
        n_checks++;
        if (wrap_total !== 2'd1 || wrap_sat !== 1'b0 || obs !== exp_vec) begin
            n_fail++; $display("FAIL sat_clr_with_wrap total=%0d sat=%b required 1,0", wrap_total, wrap_sat);
        end
        $display("test_saturation done total=%0d sat=%b", wrap_total, wrap_sat);
    endtask

    task automatic test_reset_mid_settle;
        int lat, pulses;
        for (int i = 0; i < 6; i++) tick(4'h1);
        for (int i = 0; i < 3; i++) tick(4'hA);   // third edge moves the FSM to S_SETTLE
        #2 rst = 1;
        #1;
        n_checks++;
        if (obs !== '0) begin
            n_fail++; $display("FAIL reset_async obs=%h required=0", obs);
        end
        tick(4'hA);
        rst = 0;
        lat = 0; pulses = 0;
        for (int k = 1; k <= 8; k++) begin
            tick(4'hA);
            if (cnt_valid === 1'b1 && lat == 0) lat = k;
            if (wrap_pulse || match_pulse) pulses++;
            n_checks++;
            if (obs !== exp_vec) begin
                n_fail++; $display("FAIL reacquire_model k=%0d obs=%h required=%h", k, obs, exp_vec);
            end
        end
        n_checks++;
        if (lat != STABLE + 2 || cnt_sync !== 4'hA || pulses != 0) begin
            n_fail++; $display("FAIL reacquire latency=%0d sync=%h pulses=%0d required %0d,a,0",
                               lat, cnt_sync, pulses, STABLE + 2);
        end
        $display("test_reset_mid_settle done latency=%0d", lat);
    endtask

    task automatic test_random;
        int errs = 0;
        logic [3:0] v;
        int hold;
        for (int it = 0; it < 150; it++) begin
            v    = 4'($urandom_range(0, 15));
            hold = $urandom_range(1, 4);
            if ($urandom_range(0, 7) == 0) threshold = 4'($urandom_range(0, 15));
            for (int h = 0; h < hold; h++) begin
                clr_wrap = ($urandom_range(0, 15) == 0);
                tick(v);
                n_checks++;
                if (obs !== exp_vec) begin
                    n_fail++; errs++;
                    if (errs <= 10) $display("FAIL random it=%0d obs=%h required=%h", it, obs, exp_vec);
                end
            end
        end
        clr_wrap = 0;
        $display("test_random done");
    endtask

    initial begin
        test_reset();
        test_first_accept();
        test_ripple();
        test_wrap();
        test_glitch();
        test_saturation();
        test_reset_mid_settle();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
